// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared constants and helpers for the synchronizer/debouncer bank
//
// Contents:
//   SYNC_MIN_STAGES              shallowest synchronizer chain accepted
//   SYNC_DEFAULT_DEBOUNCE_CYCLES default stable-cycle requirement
//   sync_cnt_width()             width of a counter that must hold 0..debounce_cycles
package sync_pkg;

    localparam int SYNC_MIN_STAGES              = 2;
    localparam int SYNC_DEFAULT_DEBOUNCE_CYCLES = 16;

    function automatic int sync_cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// rtl/sync_debounce_channel.sv - one-bit synchronizer chain, debouncer and edge pulse registers
//
// Build option: SYNC_DEBOUNCE_EN selects the counting debouncer; when it is
// undefined the channel is a plain synchronizer followed by an edge detector.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   in_bit  in   asynchronous raw input
//   level   out  accepted (stable) level, registered
//   rise    out  one-cycle pulse on an accepted 0->1 change, registered
//   fall    out  one-cycle pulse on an accepted 1->0 change, registered
module sync_debounce_channel
    import sync_pkg::*;
#(
    parameter int STAGES          = SYNC_MIN_STAGES,
    parameter int DEBOUNCE_CYCLES = SYNC_DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic in_bit,
    output logic level,
    output logic rise,
    output logic fall
);

    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_debounce_channel: STAGES must be at least %0d", SYNC_MIN_STAGES);
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("sync_debounce_channel: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              sync_s;
    logic              stable_q;
    logic              stable_d;
    logic              rise_q;
    logic              rise_d;
    logic              fall_q;
    logic              fall_d;

    // Bit 0 captures the raw input; the top bit is the metastability-safe sample.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], in_bit};
    end

    assign sync_s = sync_q[STAGES-1];

`ifdef SYNC_DEBOUNCE_EN
    localparam int               CNT_W    = sync_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter tracks how many consecutive cycles the synchronized sample
    // has disagreed with the accepted level. The cycle that would make the
    // run DEBOUNCE_CYCLES long accepts the new level instead of counting.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync_s != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_s;
                rise_d   = sync_s;
                fall_d   = ~sync_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // No filtering: the accepted level simply follows the synchronized sample
    // one cycle later, and the pulses mark where the two differ.
    always_comb begin
        stable_d = sync_s;
        rise_d   = sync_s & ~stable_q;
        fall_d   = ~sync_s & stable_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/sync_debounce_bank.sv
// rtl/sync_debounce_bank.sv - multi-channel input synchronizer/debouncer with edge pulses
//
// Build option: SYNC_DEBOUNCE_EN enables the per-channel debounce counters;
// without it each channel is a synchronizer plus edge detector.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset; also blanks all outputs while high
//   in        in   [CHANNELS] asynchronous raw inputs
//   level     out  [CHANNELS] conditioned level per channel
//   rise      out  [CHANNELS] one-cycle pulse when level goes 0->1
//   fall      out  [CHANNELS] one-cycle pulse when level goes 1->0
//   any_edge  out  OR of every rise and fall pulse
module sync_debounce_bank
    import sync_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int STAGES          = SYNC_MIN_STAGES,
    parameter int DEBOUNCE_CYCLES = SYNC_DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_edge
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("sync_debounce_bank: CHANNELS must be at least 1");
    end

    logic [CHANNELS-1:0] level_raw;
    logic [CHANNELS-1:0] rise_raw;
    logic [CHANNELS-1:0] fall_raw;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sync_debounce_channel #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .in_bit (in[i]),
            .level  (level_raw[i]),
            .rise   (rise_raw[i]),
            .fall   (fall_raw[i])
        );
    end

    // Outputs are held low for the whole time rst is high, not just from the
    // first reset edge, so downstream FSMs never see stale pulses during reset.
    always_comb begin
        level    = '0;
        rise     = '0;
        fall     = '0;
        any_edge = 1'b0;
        if (!rst) begin
            level    = level_raw;
            rise     = rise_raw;
            fall     = fall_raw;
            any_edge = |(rise_raw | fall_raw);
        end
    end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// tb/tb_sync_debounce_bank.sv - self-checking bench for sync_debounce_bank
module tb_sync_debounce_bank;

    localparam int CH  = 4;
    localparam int STG = 2;
    localparam int DEB = 16;
`ifdef SYNC_DEBOUNCE_EN
    localparam int DEB_EFF = DEB;
    localparam int LAT     = STG + DEB;
    localparam int NB_RISE = 1;
`else
    localparam int DEB_EFF = 1;
    localparam int LAT     = STG + 1;
    localparam int NB_RISE = 6;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] in_r;
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          any_edge;

    int checks   = 0;
    int failures = 0;

    sync_debounce_bank #(
        .CHANNELS        (CH),
        .STAGES          (STG),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in_r),
        .level    (level),
        .rise     (rise),
        .fall     (fall),
        .any_edge (any_edge)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the synchronized sample seen at an edge is the raw
    // input sampled STG edges earlier; the level flips once the last DEB_EFF
    // synchronized samples all disagree with it.
    logic [CH-1:0] in_smp;
    logic          rst_smp;
    logic          model_ready = 1'b0;

    always @(posedge clk) begin
        in_smp      <= in_r;
        rst_smp     <= rst;
        model_ready <= 1'b1;
    end

    logic [STG-1:0] m_raw   [CH];
    logic [63:0]    m_shist [CH];
    logic [CH-1:0]  m_lvl;
    logic [CH-1:0]  m_rise;
    logic [CH-1:0]  m_fall;

    always @(negedge clk) begin : model_blk
        logic        s_now;
        logic [63:0] win;
        logic [12:0] exp_v;
        #1;
        if (model_ready) begin
            m_rise = '0;
            m_fall = '0;
            win    = (64'd1 << DEB_EFF) - 64'd1;
            for (int c = 0; c < CH; c++) begin
                if (rst_smp) begin
                    m_raw[c]   = '0;
                    m_shist[c] = '0;
                    m_lvl[c]   = 1'b0;
                end else begin
                    s_now      = m_raw[c][STG-1];
                    m_raw[c]   = {m_raw[c][STG-2:0], in_smp[c]};
                    m_shist[c] = {m_shist[c][62:0], s_now};
                    if (((m_shist[c] ^ {64{m_lvl[c]}}) & win) == win) begin
                        m_lvl[c]  = s_now;
                        m_rise[c] = s_now;
                        m_fall[c] = ~s_now;
                    end
                end
            end
            exp_v = rst ? 13'd0 : {m_lvl, m_rise, m_fall, |(m_rise | m_fall)};
            check("model", 32'({level, rise, fall, any_edge}), 32'(exp_v));
        end
    end

    typedef struct {
        logic          rst;
        logic [CH-1:0] in;
        int            reps;
        logic [CH-1:0] lvl;
        logic [CH-1:0] rs;
        logic [CH-1:0] fl;
        logic          any;
    } vec_t;

    vec_t vecs[$];

    task automatic wait_level(input int ch, input logic val, output int edges);
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (level[ch] !== val && edges < 200);
    endtask

    initial begin
        int e;
        int rises;
        int last;

        rst  = 1'b1;
        in_r = '0;

        vecs.push_back('{1'b1, 4'hF, 1, 4'h0, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, 4'hF, 1, 4'h0, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b1, 4'hF, 1, 4'h0, 4'h0, 4'h0, 1'b0});
`ifdef SYNC_DEBOUNCE_EN
        vecs.push_back('{1'b0, 4'hF, 17, 4'h0, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 1,  4'hF, 4'hF, 4'h0, 1'b1});
        vecs.push_back('{1'b0, 4'hF, 1,  4'hF, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hD, 15, 4'hF, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 20, 4'hF, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'h0, 17, 4'hF, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'h0, 1,  4'h0, 4'h0, 4'hF, 1'b1});
        vecs.push_back('{1'b0, 4'h2, 15, 4'h0, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'h0, 20, 4'h0, 4'h0, 4'h0, 1'b0});
`else
        vecs.push_back('{1'b0, 4'h1, 1, 4'h0, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 1, 4'h1, 4'h1, 4'h0, 1'b1});
        vecs.push_back('{1'b0, 4'hF, 1, 4'h0, 4'h0, 4'h1, 1'b1});
        vecs.push_back('{1'b0, 4'h8, 1, 4'hF, 4'hF, 4'h0, 1'b1});
        vecs.push_back('{1'b0, 4'h0, 1, 4'hF, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'h0, 1, 4'h8, 4'h0, 4'h7, 1'b1});
        vecs.push_back('{1'b0, 4'h0, 1, 4'h0, 4'h0, 4'h8, 1'b1});
        vecs.push_back('{1'b0, 4'h8, 1, 4'h0, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'h0, 1, 4'h8, 4'h8, 4'h0, 1'b1});
        vecs.push_back('{1'b0, 4'h0, 1, 4'h0, 4'h0, 4'h8, 1'b1});
`endif

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst  = vecs[i].rst;
            in_r = vecs[i].in;
            repeat (vecs[i].reps) @(negedge clk);
            check($sformatf("vec%0d_level", i), 32'(level),    32'(vecs[i].lvl));
            check($sformatf("vec%0d_rise", i),  32'(rise),     32'(vecs[i].rs));
            check($sformatf("vec%0d_fall", i),  32'(fall),     32'(vecs[i].fl));
            check($sformatf("vec%0d_any", i),   32'(any_edge), 32'(vecs[i].any));
        end

        // Clean press and release on channel 0.
        in_r = 4'b0001;
        wait_level(0, 1'b1, e);
        check("press_latency", 32'(e), 32'(LAT));
        check("press_rise", 32'(rise), 32'h1);
        @(negedge clk);
        check("press_rise_width", 32'(rise), 32'h0);
        in_r = 4'b0000;
        wait_level(0, 1'b0, e);
        check("release_latency", 32'(e), 32'(LAT));
        check("release_fall", 32'(fall), 32'h1);

        // Reset part-way through qualification restarts the full latency.
        in_r = 4'hF;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_gate", 32'({level, rise, fall, any_edge}), 32'h0);
        rst = 1'b0;
        wait_level(3, 1'b1, e);
        check("rereset_latency", 32'(e), 32'(LAT));
        check("simul_rise", 32'(rise), 32'hF);
        check("simul_any", 32'(any_edge), 32'h1);
        @(negedge clk);
        check("simul_any_width", 32'(any_edge), 32'h0);

        // Bounce on channel 2, then held high.
        in_r = 4'h0;
        repeat (LAT + 4) @(negedge clk);
        rises = 0;
        last  = 0;
        for (int c = 0; c < 30; c++) begin
            in_r[2] = ((c / 3) % 2 == 0);
            @(negedge clk);
            if (rise[2]) rises++;
        end
        in_r[2] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rise[2]) begin
                rises++;
                last = k;
            end
        end
        check("bounce_rises", 32'(rises), 32'(NB_RISE));
        check("bounce_latency", 32'(last), 32'(LAT));

        // Random traffic with occasional resets, checked by the model.
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 19) == 0) in_r[c] = ~in_r[c];
            end
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
